neuron_mac_node: RTL and testbench
==================================

NEURON_MAC_NODE -- requirements
Module: neuron_mac_node

Interface
REQ-001 Parameter N_IN, default 5: number of inputs (synapses) to the node, 1..64.
REQ-002 Parameter DW, default 8: width of inputs, weights, bias and output, in signed two's complement.
REQ-003 Parameter FRAC, default 0: arithmetic right shift applied to the accumulator before saturation.
REQ-004 Parameter RELU, default 1: 1 clamps negative results to 0; 0 passes signed results through.
REQ-005 Derived constants: AW = 2*DW + clog2(N_IN) + 1 (accumulator width); IW = clog2(N_IN+1) (weight address width).
REQ-006 clk  input  1  clock; reset is synchronous and active-high.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  input vector valid.
REQ-009 in_ready  output  1  node can accept an input vector.
REQ-010 in_data  input  N_IN*DW  packed signed inputs; element i occupies bits [i*DW +: DW].
REQ-011 w_we  input  1  weight/bias write strobe.
REQ-012 w_addr  input  IW  addresses 0..N_IN-1 select weights; address N_IN selects the bias.
REQ-013 w_data  input  DW  signed weight or bias value.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 out_data  output  DW  activated result.
REQ-017 busy  output  1  high in MAC or OUT state.

Function
REQ-018 The FSM SHALL have three states: IDLE, MAC and OUT.
REQ-019 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-020 On in_valid && in_ready: capture in_data, load acc with the sign-extended bias shifted left by FRAC, clear the index counter, and go to MAC.
REQ-021 In MAC: each cycle, acc SHALL add in[idx]*w[idx] (full-precision signed product); idx SHALL increment; after idx = N_IN-1 the FSM SHALL go to OUT.
REQ-022 On entry to OUT, out_data SHALL be registered as follows:
- s = acc >>> FRAC (arithmetic shift, rounding toward -inf);
- saturate s to [-2^(DW-1), 2^(DW-1)-1];
- if RELU=1 and the result is negative, force it to 0.
REQ-023 Latency: with the handshake accepted at cycle 0, out_valid SHALL rise at cycle N_IN+1.
REQ-024 In OUT, out_valid SHALL be 1, and out_data SHALL be held stable until out_valid && out_ready. The FSM then returns to IDLE, and in_ready = 1 in the following cycle.
REQ-025 Weight writes SHALL take effect the next cycle when the state is IDLE or OUT. Writes during MAC SHALL be ignored. Writes with w_addr > N_IN SHALL be ignored.
REQ-026 in_valid SHALL be ignored while in_ready = 0; captured inputs are not affected by later in_data changes.
REQ-027 The accumulator SHALL NOT overflow for any inputs or weights, given the AW sizing above.

Reset
REQ-028 On reset, state SHALL be IDLE; out_valid, out_data, acc, idx, captured inputs, all weights and bias SHALL be 0; in_ready SHALL be 1 and busy SHALL be 0 in the next cycle.
REQ-029 Reset asserted in MAC or OUT SHALL abort the computation with no result emitted. Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-030 DW, FRAC defaults, the state enum and the saturate/ReLU function SHALL reside in shared package nn_node_pkg.
REQ-031 Saturation and activation SHALL be a sub-module, nn_sat_act (combinational, parametrised by AW, DW, FRAC, RELU), instantiated once.
REQ-032 Weights SHALL be held in a register array of N_IN+1 entries; a single multiplier SHALL be time-multiplexed.

Verification (N_IN=5, DW=8, FRAC=0; weights 43,66,-79,-83,-117; bias 33)
REQ-033 All inputs 0, RELU=1 -> out_data=33, with out_valid at cycle 6 after accept.
REQ-034 in0=1, others 0 -> 76; in0=100 -> 4333 saturates to 127.
REQ-035 in2=10 -> -757: RELU=1 gives 0; RELU=0 gives -128.
REQ-036 out_ready held low 3 cycles in OUT -> out_data stable, in_ready=0, second in_valid ignored; result consumed on the 4th cycle.
REQ-037 w_we to address 0 with 1 during MAC -> current result unchanged (76 for in0=1); the same write in IDLE -> next result 34.
REQ-038 Reset asserted at cycle 3 of MAC -> out_valid never rises; in_ready=1 next cycle; weights 0, so a new vector yields 0.

Source files
------------

// File: rtl/nn_node_pkg.sv
// Shared types and helpers for the neuron MAC node: default widths, FSM state
// encoding and the saturate/ReLU function used by the activation stage.
package nn_node_pkg;

    localparam int DW_DEFAULT   = 8;
    localparam int FRAC_DEFAULT = 0;

    // Working width of the saturate function; wide enough for any realistic AW.
    localparam int SAT_MAXW = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Clamp s into the signed dw-bit range, then optionally clamp negatives to 0.
    function automatic logic signed [SAT_MAXW-1:0] sat_act(
        input logic signed [SAT_MAXW-1:0] s,
        input int unsigned                dw,
        input logic                       relu
    );
        logic signed [SAT_MAXW-1:0] max_v;
        logic signed [SAT_MAXW-1:0] min_v;
        logic signed [SAT_MAXW-1:0] r;
        max_v = (SAT_MAXW'(1) << (dw - 1)) - SAT_MAXW'(1);
        min_v = ~max_v;
        if (s > max_v) begin
            r = max_v;
        end else if (s < min_v) begin
            r = min_v;
        end else begin
            r = s;
        end
        if (relu && r[SAT_MAXW-1]) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_sat_act.sv
// Combinational output stage: fixed-point rescale of the accumulator followed
// by saturation to DW bits and optional ReLU.
module nn_sat_act
    import nn_node_pkg::*;
#(
    parameter int AW   = 24,
    parameter int DW   = DW_DEFAULT,
    parameter int FRAC = FRAC_DEFAULT,
    parameter int RELU = 1
) (
    input  logic signed [AW-1:0] acc_in,
    output logic signed [DW-1:0] result
);

    logic signed [AW-1:0]       shifted;
    logic signed [SAT_MAXW-1:0] wide;
    logic signed [SAT_MAXW-1:0] sat;
    logic                       unused_sat_hi;

    always_comb begin
        // Arithmetic shift, so fractional bits round toward minus infinity.
        shifted = acc_in >>> FRAC;
        wide    = {{(SAT_MAXW-AW){shifted[AW-1]}}, shifted};
        sat     = sat_act(wide, DW, RELU != 0);
        result  = sat[DW-1:0];
    end

    assign unused_sat_hi = ^sat[SAT_MAXW-1:DW];

endmodule

// File: rtl/neuron_mac_node.sv
// Single neuron: captures an input vector, accumulates bias + sum(in*w) with one
// time-multiplexed multiplier, then presents the saturated/activated result.
module neuron_mac_node
    import nn_node_pkg::*;
#(
    parameter int N_IN = 5,
    parameter int DW   = DW_DEFAULT,
    parameter int FRAC = FRAC_DEFAULT,
    parameter int RELU = 1,
    localparam int AW  = 2*DW + $clog2(N_IN) + 1,
    localparam int IW  = $clog2(N_IN+1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_IN*DW-1:0] in_data,
    input  logic               w_we,
    input  logic [IW-1:0]      w_addr,
    input  logic [DW-1:0]      w_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic               busy
);

    state_t                state_q, state_d;
    logic signed [DW-1:0]  in_vec [N_IN];
    logic signed [DW-1:0]  in_q   [N_IN];
    logic signed [DW-1:0]  in_d   [N_IN];
    logic signed [DW-1:0]  w_q    [N_IN+1];
    logic signed [DW-1:0]  w_d    [N_IN+1];
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [AW-1:0]  acc_sum;
    logic signed [AW-1:0]  bias_init;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  out_valid_q, out_valid_d;
    logic signed [DW-1:0]  out_data_q, out_data_d;
    logic signed [DW-1:0]  act_result;
    logic signed [DW-1:0]  in_sel, w_sel;
    logic signed [2*DW-1:0] product;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_unpack
            assign in_vec[gi] = in_data[gi*DW +: DW];
        end
    endgenerate

    // Operand select for the shared multiplier.
    always_comb begin
        in_sel = '0;
        w_sel  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (idx_q == IW'(i)) begin
                in_sel = in_q[i];
                w_sel  = w_q[i];
            end
        end
    end

    always_comb begin
        product   = in_sel * w_sel;
        acc_sum   = acc_q + {{(AW-2*DW){product[2*DW-1]}}, product};
        bias_init = {{(AW-DW){w_q[N_IN][DW-1]}}, w_q[N_IN]} <<< FRAC;
    end

    // Fed with the running sum so the last product lands in out_data on entry to OUT.
    nn_sat_act #(
        .AW   (AW),
        .DW   (DW),
        .FRAC (FRAC),
        .RELU (RELU)
    ) u_sat_act (
        .acc_in (acc_sum),
        .result (act_result)
    );

    always_comb begin
        state_d     = state_q;
        in_d        = in_q;
        w_d         = w_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        // Coefficients are frozen while a vector is being accumulated.
        if (w_we && (state_q != ST_MAC) && (w_addr <= IW'(N_IN))) begin
            w_d[w_addr] = w_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    in_d    = in_vec;
                    acc_d   = bias_init;
                    idx_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_sum;
                if (idx_q == IW'(N_IN-1)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = act_result;
                    state_d     = ST_OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < N_IN; i++) begin
                in_q[i] <= '0;
            end
            for (int i = 0; i <= N_IN; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_q        <= in_d;
            w_q         <= w_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_neuron_mac_node.sv
// Directed bench for neuron_mac_node: a ReLU and a linear instance run in lockstep,
// expected results are queued at accept time and popped when the node presents them.
module tb_neuron_mac_node;

    localparam int N_IN = 5;
    localparam int DW   = 8;
    localparam int IW   = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic [N_IN*DW-1:0] in_data;
    logic               w_we;
    logic [IW-1:0]      w_addr;
    logic [DW-1:0]      w_data;
    logic               out_ready;

    logic               in_ready, out_valid, busy;
    logic [DW-1:0]      out_data;
    logic               in_ready_l, out_valid_l, busy_l;
    logic [DW-1:0]      out_data_l;

    int checks = 0;
    int errors = 0;
    int w_sh [6];
    int exp_q1 [$];
    int exp_q0 [$];

    always #5 clk = ~clk;

    neuron_mac_node #(.N_IN(N_IN), .DW(DW), .FRAC(0), .RELU(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    neuron_mac_node #(.N_IN(N_IN), .DW(DW), .FRAC(0), .RELU(0)) dut_lin (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .in_data   (in_data),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .out_valid (out_valid_l),
        .out_ready (out_ready),
        .out_data  (out_data_l),
        .busy      (busy_l)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model(input logic [N_IN*DW-1:0] v, input bit relu);
        int s;
        int xi;
        s = w_sh[N_IN];
        for (int i = 0; i < N_IN; i++) begin
            xi = $signed(v[i*DW +: DW]);
            s += xi * w_sh[i];
        end
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    task automatic write_w(input int addr, input int data);
        w_we   = 1'b1;
        w_addr = IW'(addr);
        w_data = DW'(data);
        tick();
        w_we = 1'b0;
        if (addr <= N_IN) w_sh[addr] = data;
        $display("write  addr=%0d data=%0d", addr, data);
    endtask

    // One full transaction: handshake, latency, optional back-pressure, result check.
    task automatic run_vec(input logic [N_IN*DW-1:0] v, input int hold, input bit mac_wr,
                           input string tag);
        int lat;
        int wait_n;
        int r1;
        int r0;
        in_valid = 1'b1;
        in_data  = v;
        wait_n   = 0;
        while (!in_ready && wait_n < 20) begin
            tick();
            wait_n++;
        end
        chk({tag, " in_ready"}, int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_data  = ~v;
        exp_q1.push_back(model(v, 1'b1));
        exp_q0.push_back(model(v, 1'b0));
        out_ready = (hold == 0);
        lat = 1;
        chk({tag, " busy"}, int'(busy), 1);
        chk({tag, " ready_low"}, int'(in_ready), 0);
        if (mac_wr) begin
            w_we   = 1'b1;
            w_addr = '0;
            w_data = 8'd1;
            tick();
            lat++;
            w_we = 1'b0;
        end
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, N_IN + 1);
        for (int h = 0; h < hold; h++) begin
            chk({tag, " hold_data"}, int'($signed(out_data)), exp_q1[0]);
            chk({tag, " hold_ready"}, int'(in_ready), 0);
            in_valid = 1'b1;
            in_data  = 40'h64;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, " valid"}, int'(out_valid), 1);
        chk({tag, " valid_lin"}, int'(out_valid_l), 1);
        r1 = exp_q1.pop_front();
        r0 = exp_q0.pop_front();
        chk({tag, " data_relu"}, int'($signed(out_data)), r1);
        chk({tag, " data_lin"}, int'($signed(out_data_l)), r0);
        $display("vector %s in=%h relu=%0d lin=%0d exp=%0d/%0d lat=%0d",
                 tag, v, $signed(out_data), $signed(out_data_l), r1, r0, lat);
        tick();
        chk({tag, " drop_valid"}, int'(out_valid), 0);
        chk({tag, " ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        logic [N_IN*DW-1:0] rv;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        out_ready = 1'b1;
        for (int i = 0; i <= N_IN; i++) w_sh[i] = 0;
        tick();
        tick();
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_data", int'(out_data), 0);
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst busy", int'(busy), 0);
        reset = 1'b0;
        tick();

        write_w(0, 43);
        write_w(1, 66);
        write_w(2, -79);
        write_w(3, -83);
        write_w(4, -117);
        write_w(5, 33);
        write_w(6, 99);
        write_w(7, -5);

        run_vec(40'h00_0000_0000, 0, 1'b0, "zeros");
        run_vec(40'h00_0000_0001, 0, 1'b0, "in0_1");
        run_vec(40'h00_0000_0064, 0, 1'b0, "in0_100");
        run_vec(40'h00_000A_0000, 0, 1'b0, "in2_10");
        run_vec(40'h00_0100_FF02, 0, 1'b0, "mixed_neg");
        run_vec(40'h00_0001_0101, 0, 1'b0, "mixed_pos");
        for (int k = 0; k < 3; k++) begin
            rv[31:0]  = $urandom;
            rv[39:32] = 8'($urandom);
            run_vec(rv, 0, 1'b0, "random");
        end

        run_vec(40'h00_0000_0001, 3, 1'b0, "backpressure");
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("ignored_vector", seen, 0);

        run_vec(40'h00_0000_0001, 0, 1'b1, "mac_write");
        write_w(0, 1);
        run_vec(40'h00_0000_0001, 0, 1'b0, "idle_write");

        in_valid = 1'b1;
        in_data  = 40'h00_0000_0001;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i <= N_IN; i++) w_sh[i] = 0;
        chk("abort in_ready", int'(in_ready), 1);
        chk("abort busy", int'(busy), 0);
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort out_data", int'(out_data), 0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid || out_valid_l) seen++;
            tick();
        end
        chk("abort no_result", seen, 0);
        $display("reset abort checked");
        run_vec(40'h00_0000_0001, 0, 1'b0, "post_reset");
        run_vec(40'h00_000A_0064, 0, 1'b0, "post_reset2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
